acumulador_com_sinal: RTL and testbench

ACUMULADOR_COM_SINAL -- requirements
Module: acumulador_com_sinal

---
 rtl/acumulador_com_sinal_if.sv | 25 ++
 rtl/acumulador_com_sinal.sv | 102 ++++++++++
 tb/tb_acumulador_com_sinal.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/acumulador_com_sinal_if.sv
// Handshake and result bus for the signed window accumulator.
// The accumulator is the slave; the producer/consumer side is the master.
interface acumulador_com_sinal_if;
    logic signed [7:0]  entrada;
    logic               entrada_valida;
    logic               entrada_pronta;
    logic               limpar;
    logic               saida_valida;
    logic               saida_pronta;
    logic signed [11:0] soma;
    logic signed [7:0]  media;
    logic signed [7:0]  saida_sat;
    logic               saturou;
    logic [4:0]         contagem;

    modport slave (
        input  entrada, entrada_valida, limpar, saida_pronta,
        output entrada_pronta, saida_valida, soma, media, saida_sat, saturou, contagem
    );

    modport master (
        output entrada, entrada_valida, limpar, saida_pronta,
        input  entrada_pronta, saida_valida, soma, media, saida_sat, saturou, contagem
    );
endinterface

// File: rtl/acumulador_com_sinal.sv
// Signed window accumulator: sums N_AMOSTRAS signed 8-bit samples, then holds
// sum, floor mean and saturated sum until the consumer takes them.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ACUMULANDO | accepting samples, results track the running sum
// PRONTO     | window complete, results held until saida_pronta or limpar
module acumulador_com_sinal #(
    parameter int N_AMOSTRAS = 4
) (
    input logic clk,
    input logic rst,
    acumulador_com_sinal_if.slave bus
);
    localparam int LOG2_N = $clog2(N_AMOSTRAS);

    generate
        if (N_AMOSTRAS != 2 && N_AMOSTRAS != 4 && N_AMOSTRAS != 8 && N_AMOSTRAS != 16) begin : g_bad_n
            $error("acumulador_com_sinal: N_AMOSTRAS must be 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic {
        ACUMULANDO = 1'b0,
        PRONTO     = 1'b1
    } estado_t;

    estado_t            estado_q, estado_d;
    logic signed [11:0] acc_q, acc_d;
    logic [4:0]         cnt_q, cnt_d;
    logic signed [7:0]  media_q, media_d;
    logic signed [7:0]  sat_q, sat_d;
    logic               saturou_q, saturou_d;
    logic signed [11:0] media_larga;

    // Next-state: limpar beats the output handshake, which beats sample accept.
    always_comb begin
        estado_d = estado_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (bus.limpar) begin
            estado_d = ACUMULANDO;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (estado_q == PRONTO) begin
            if (bus.saida_pronta) begin
                estado_d = ACUMULANDO;
                acc_d    = '0;
                cnt_d    = '0;
            end
        end else if (bus.entrada_valida) begin
            acc_d = acc_q + 12'(bus.entrada);
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(N_AMOSTRAS - 1)) begin
                estado_d = PRONTO;
            end
        end
    end

    // Derived results are computed from the next accumulator so they are
    // registered alongside it and never lag the sum by a cycle.
    always_comb begin
        media_larga = acc_d >>> LOG2_N;
        media_d     = media_larga[7:0];
        sat_d       = acc_d[7:0];
        saturou_d   = 1'b0;
        if (acc_d > 12'sd127) begin
            sat_d     = 8'sd127;
            saturou_d = 1'b1;
        end else if (acc_d < -12'sd128) begin
            sat_d     = -8'sd128;
            saturou_d = 1'b1;
        end
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q  <= ACUMULANDO;
            acc_q     <= '0;
            cnt_q     <= '0;
            media_q   <= '0;
            sat_q     <= '0;
            saturou_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            media_q   <= media_d;
            sat_q     <= sat_d;
            saturou_q <= saturou_d;
        end
    end

    assign bus.entrada_pronta = (estado_q == ACUMULANDO);
    assign bus.saida_valida   = (estado_q == PRONTO);
    assign bus.soma           = acc_q;
    assign bus.media          = media_q;
    assign bus.saida_sat      = sat_q;
    assign bus.saturou        = saturou_q;
    assign bus.contagem       = cnt_q;
endmodule

// File: tb/tb_acumulador_com_sinal.sv
// Directed bench for acumulador_com_sinal with N_AMOSTRAS = 4.
module tb_acumulador_com_sinal;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    acumulador_com_sinal_if bus ();

    acumulador_com_sinal #(.N_AMOSTRAS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        bus.entrada        = 8'(v);
        bus.entrada_valida = 1'b1;
        tick();
        bus.entrada_valida = 1'b0;
    endtask

    task automatic chk_res(input string tag, input int s, input int m, input int st, input int sa);
        chk({tag, ".valid"}, int'(bus.saida_valida), 1);
        chk({tag, ".pronta"}, int'(bus.entrada_pronta), 0);
        chk({tag, ".soma"}, $signed(bus.soma), s);
        chk({tag, ".media"}, $signed(bus.media), m);
        chk({tag, ".sat"}, $signed(bus.saida_sat), st);
        chk({tag, ".saturou"}, int'(bus.saturou), sa);
        chk({tag, ".contagem"}, int'(bus.contagem), 4);
    endtask

    task automatic handshake(input string tag);
        bus.saida_pronta = 1'b1;
        tick();
        bus.saida_pronta = 1'b0;
        chk({tag, ".hs_valid"}, int'(bus.saida_valida), 0);
        chk({tag, ".hs_cont"}, int'(bus.contagem), 0);
        chk({tag, ".hs_soma"}, $signed(bus.soma), 0);
        chk({tag, ".hs_pronta"}, int'(bus.entrada_pronta), 1);
    endtask

    initial begin
        n_checks           = 0;
        n_errors           = 0;
        rst                = 1'b1;
        bus.entrada        = '0;
        bus.entrada_valida = 1'b0;
        bus.limpar         = 1'b0;
        bus.saida_pronta   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        chk("rst.soma", $signed(bus.soma), 0);
        chk("rst.media", $signed(bus.media), 0);
        chk("rst.sat", $signed(bus.saida_sat), 0);
        chk("rst.saturou", int'(bus.saturou), 0);
        chk("rst.valid", int'(bus.saida_valida), 0);
        chk("rst.pronta", int'(bus.entrada_pronta), 1);
        chk("rst.cont", int'(bus.contagem), 0);

        // 10,20,30,40; valid one edge after the 4th, not earlier
        send(10);
        chk("w1.run_soma", $signed(bus.soma), 10);
        send(20);
        send(30);
        chk("w1.pre_valid", int'(bus.saida_valida), 0);
        chk("w1.pre_cont", int'(bus.contagem), 3);
        chk("w1.run_media", $signed(bus.media), 15);
        send(40);
        chk_res("w1", 100, 25, 100, 0);
        handshake("w1");

        send(-128); send(-128); send(-128); send(-128);
        chk_res("w2", -512, -128, -128, 1);
        handshake("w2");

        send(-1); send(-1); send(-1); send(-2);
        chk_res("w3", -5, -2, -5, 0);
        handshake("w3");

        send(127); send(127); send(-1); send(-1);
        chk_res("w4", 252, 63, 127, 1);
        handshake("w4");

        // Backpressure: hold results for 3 cycles with valid input pending
        send(10); send(20); send(30); send(40);
        bus.entrada        = 8'sd99;
        bus.entrada_valida = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_res("hold", 100, 25, 100, 0);
        end
        handshake("hold");
        bus.entrada_valida = 1'b0;
        tick();
        chk("hold.no_accept", int'(bus.contagem), 0);

        // saida_pronta in ACUMULANDO is ignored
        bus.saida_pronta = 1'b1;
        send(3);
        send(4);
        bus.saida_pronta = 1'b0;
        chk("ign.cont", int'(bus.contagem), 2);
        chk("ign.soma", $signed(bus.soma), 7);
        bus.limpar = 1'b1;
        tick();
        bus.limpar = 1'b0;

        // limpar discards a simultaneous sample
        send(5); send(6);
        bus.limpar         = 1'b1;
        bus.entrada        = 8'sd9;
        bus.entrada_valida = 1'b1;
        tick();
        bus.limpar         = 1'b0;
        bus.entrada_valida = 1'b0;
        chk("clr.cont", int'(bus.contagem), 0);
        chk("clr.soma", $signed(bus.soma), 0);
        send(1); send(2); send(3); send(4);
        chk_res("clr", 10, 2, 10, 0);

        // limpar in PRONTO drops valid next cycle
        bus.limpar = 1'b1;
        tick();
        bus.limpar = 1'b0;
        chk("clrp.valid", int'(bus.saida_valida), 0);
        chk("clrp.cont", int'(bus.contagem), 0);

        // rst in a partial window
        send(1); send(2); send(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstw.soma", $signed(bus.soma), 0);
        chk("rstw.media", $signed(bus.media), 0);
        chk("rstw.cont", int'(bus.contagem), 0);
        chk("rstw.valid", int'(bus.saida_valida), 0);
        send(1); send(1); send(1); send(1);
        chk_res("rstw", 4, 1, 4, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
